// File: rtl/reg_bank8x16.sv
// reg_bank8x16: eight-entry register bank with a per-register busy scoreboard and a consumer stall.
// Multicycle producers reserve a destination register; the write that later lands on it completes the reservation.
module reg_bank8x16 #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rsv,
    input  logic [2:0]       rsv_addr,
    input  logic             chk_en,
    input  logic [2:0]       chk_a,
    input  logic [2:0]       chk_b,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [7:0]       busy,
    output logic             stall,
    output logic             ovr_err
);
    logic [WIDTH-1:0] r_mem [8];
    logic [7:0]       r_busy;
    logic             r_ovr;
    logic [7:0]       w_clr;
    logic [7:0]       w_set;
    logic             w_ovr_hit;

    assign w_clr = we  ? 8'(1) << waddr    : 8'h00;
    assign w_set = rsv ? 8'(1) << rsv_addr : 8'h00;
    // A same-cycle write to the reserved index retires the old reservation, so that is not an overrun.
    assign w_ovr_hit = rsv & r_busy[rsv_addr] & ~(we & (waddr == rsv_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_mem[i] <= RST_VAL;
            r_busy <= 8'h00;
            r_ovr  <= 1'b0;
        end else begin
            if (we) r_mem[waddr] <= wdata;
            r_busy <= (r_busy & ~w_clr) | w_set;
            r_ovr  <= r_ovr | w_ovr_hit;
        end
    end

    assign q0      = r_mem[0];
    assign q1      = r_mem[1];
    assign q2      = r_mem[2];
    assign q3      = r_mem[3];
    assign q4      = r_mem[4];
    assign q5      = r_mem[5];
    assign q6      = r_mem[6];
    assign q7      = r_mem[7];
    assign busy    = r_busy;
    assign ovr_err = r_ovr;
    assign stall   = chk_en & (r_busy[chk_a] | r_busy[chk_b]);
endmodule

// File: tb/tb_reg_bank8x16.sv
// tb_reg_bank8x16: directed scenarios plus random traffic checked against a behavioural register/scoreboard model.
module tb_reg_bank8x16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        rsv;
    logic [2:0]  rsv_addr;
    logic        chk_en;
    logic [2:0]  chk_a;
    logic [2:0]  chk_b;
    logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]  busy;
    logic        stall;
    logic        ovr_err;
    logic [15:0] q [8];

    logic [15:0] m_reg [8];
    logic [7:0]  m_busy;
    logic        m_ovr;
    int          n_chk = 0;
    int          n_err = 0;

    reg_bank8x16 dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv(rsv), .rsv_addr(rsv_addr), .chk_en(chk_en), .chk_a(chk_a), .chk_b(chk_b),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .busy(busy), .stall(stall), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;
    assign q = '{q0, q1, q2, q3, q4, q5, q6, q7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
        m_busy = 8'h00;
        m_ovr  = 1'b0;
    endtask

    // One clock edge as the spec describes it: write, clear-then-set busy, sticky overrun.
    task automatic model_edge();
        if (rsv && m_busy[rsv_addr] && !(we && waddr == rsv_addr)) m_ovr = 1'b1;
        if (we) begin
            m_reg[waddr]  = wdata;
            m_busy[waddr] = 1'b0;
        end
        if (rsv) m_busy[rsv_addr] = 1'b1;
    endtask

    task automatic check_all();
        for (int i = 0; i < 8; i++) check($sformatf("q%0d", i), 32'(q[i]), 32'(m_reg[i]));
        check("busy", 32'(busy), 32'(m_busy));
        check("ovr_err", 32'(ovr_err), 32'(m_ovr));
        check("stall", 32'(stall), 32'(chk_en && (m_busy[chk_a] || m_busy[chk_b])));
    endtask

    task automatic idle();
        we = 0; rsv = 0; chk_en = 0; waddr = 0; rsv_addr = 0; wdata = 0; chk_a = 0; chk_b = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] sweep [8];
        sweep = '{16'd1, 16'd3, 16'd7, 16'd4, 16'd9, 16'd23, 16'd10, 16'd54};
        idle();
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        // dirty the bank, then reset between edges
        we = 1; waddr = 3; wdata = 16'hBEEF; rsv = 1; rsv_addr = 1;
        step();
        idle();
        mid_reset();
        // write sweep
        for (int i = 0; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = sweep[i];
            step();
        end
        idle();
        check("mux_set5", 32'(q[5]), 32'd23);
        // scoreboard
        rsv = 1; rsv_addr = 2;
        step();
        idle();
        chk_en = 1; chk_a = 2; chk_b = 6;
        #1 check("stall_pend", 32'(stall), 32'd1);
        check("busy_pend", 32'(busy), 32'h04);
        we = 1; waddr = 2; wdata = 16'h00AA;
        step();
        we = 0;
        #1 check("stall_free", 32'(stall), 32'd0);
        check("q2_aa", 32'(q2), 32'h00AA);
        idle();
        // collision then overrun
        we = 1; waddr = 5; wdata = 16'h1234; rsv = 1; rsv_addr = 5;
        step();
        check("q5_coll", 32'(q5), 32'h1234);
        check("busy_coll", 32'(busy), 32'h20);
        check("ovr_before", 32'(ovr_err), 32'd0);
        we = 0;
        step();
        check("ovr_set", 32'(ovr_err), 32'd1);
        idle();
        we = 1; waddr = 5; wdata = 16'h5555;
        step();
        we = 1; waddr = 0; wdata = 16'h7777;
        step();
        check("ovr_sticky", 32'(ovr_err), 32'd1);
        idle();
        // fill the scoreboard, then reset mid-operation
        for (int i = 0; i < 8; i++) begin
            rsv = 1; rsv_addr = 3'(i);
            step();
        end
        idle();
        check("busy_full", 32'(busy), 32'hFF);
        chk_en = 1; chk_a = 4; chk_b = 4;
        mid_reset();
        check("busy_rst", 32'(busy), 32'h00);
        idle();
        // random traffic, with an occasional asynchronous reset
        for (int n = 0; n < 400; n++) begin
            we       = 1'($urandom_range(0, 1));
            waddr    = 3'($urandom);
            wdata    = 16'($urandom);
            rsv      = ($urandom_range(0, 2) == 0);
            rsv_addr = 3'($urandom);
            chk_en   = 1'($urandom_range(0, 1));
            chk_a    = 3'($urandom);
            chk_b    = ($urandom_range(0, 3) == 0) ? chk_a : 3'($urandom);
            #1 check("stall_comb", 32'(stall), 32'(chk_en && (m_busy[chk_a] || m_busy[chk_b])));
            step();
            if ($urandom_range(0, 79) == 0) mid_reset();
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
